// File: rtl/dmem_pkg.sv
// Shared definitions for the MEM-stage data-memory responder:
// FSM state encoding, latency counter sizing and small address helpers.
package dmem_pkg;

  // Largest supported access latency; the counter is sized to hold LAT_MAX-1.
  localparam int LAT_MAX = 15;
  localparam int CNT_W   = 4;

  // Responder FSM states (2-bit encoding, value 3 unused).
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // A word access must have the two byte-offset bits clear.
  function automatic logic addr_misaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

  // A request asking for both load and store at once is malformed.
  function automatic logic op_conflict(input logic rd, input logic wr);
    return rd & wr;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Synchronous single-port word RAM behind the responder.
// Write and registered read share one index; contents are never reset.
module dmem_array #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [2**AW];

  // Store on we; capture the addressed word into rdata on re.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wdata;
    end
    if (re) begin
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder. Accepts one load/store from EX/MEM,
// stalls the upstream pipeline for a fixed latency, performs the access,
// then pulses Done for one cycle so EX/MEM can advance.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int AW  = 10,
  parameter int LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Addr,
  input  logic [31:0] WData,
  output logic [31:0] RData,
  output logic        Stall,
  output logic        Done,
  output logic        Err
);

  generate
    if (LAT < 1 || LAT > LAT_MAX) begin : g_bad_lat
      $error("dmem_responder: LAT must be in 1..15");
    end
  endgenerate

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             req;
  logic             accept;
  logic             fire;
  logic             bad_req;
  logic             op_wr;
  logic [AW-1:0]    idx_q;
  logic [31:0]      wdata_q;
  logic             rdata_vld;
  logic [31:0]      arr_rdata;
  logic             arr_we;
  logic             arr_re;
  logic             unused_addr;

  assign req     = MemRead | MemWrite;
  assign accept  = (state == S_IDLE) && req;
  assign fire    = (state == S_BUSY) && (cnt == '0);
  assign bad_req = op_conflict(MemRead, MemWrite) | addr_misaligned(Addr);

  // Upper address bits wrap away; they are deliberately not decoded.
  assign unused_addr = ^Addr[31:AW+2];

  // Next-state logic: DONE always returns to IDLE so a held request is not re-taken.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (req) begin
          state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        if (cnt == '0) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State register; reset abandons any access in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Latency counter: loaded on accept, counts down while BUSY.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= CNT_LOAD;
    end else if ((state == S_BUSY) && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Completion pulse, registered at the edge the access is performed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      Done <= 1'b0;
    end else begin
      Done <= fire;
    end
  end

  // Sticky error flag for conflicting or misaligned requests.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      Err <= 1'b0;
    end else if (accept && bad_req) begin
      Err <= 1'b1;
    end
  end

  // Latched operation; a simultaneous read+write resolves to a store.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_wr <= 1'b0;
    end else if (accept) begin
      op_wr <= MemWrite;
    end
  end

  // Marks that the array read register holds a real load result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_vld <= 1'b0;
    end else if (fire && !op_wr) begin
      rdata_vld <= 1'b1;
    end
  end

  // Operand latch: address index and store data, frozen for the BUSY phase.
  always_ff @(posedge clk) begin
    if (accept) begin
      idx_q   <= Addr[AW+1:2];
      wdata_q <= WData;
    end
  end

  assign arr_we = fire & op_wr;
  assign arr_re = fire & ~op_wr;

  dmem_array #(
    .AW(AW)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .re    (arr_re),
    .idx   (idx_q),
    .wdata (wdata_q),
    .rdata (arr_rdata)
  );

  // Load data reads as zero until the first load after reset completes,
  // then holds until the next load; stores never touch it.
  assign RData = rdata_vld ? arr_rdata : 32'h0;

  // Hold the pipeline while a request is pending or in flight; drop at once in reset.
  assign Stall = rst & (accept | (state == S_BUSY));

endmodule

// File: tb/tb_dmem_responder.sv
// Directed testbench for dmem_responder: LAT=2 main instance plus
// LAT=1 and LAT=15 instances for the latency sweep.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Addr;
  logic [31:0] WData;
  logic [2:0]  stall_v;
  logic [2:0]  done_v;
  logic [2:0]  err_v;
  logic [31:0] rdata_v [3];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  dmem_responder #(.AW(10), .LAT(2)) u_lat2 (
    .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite), .Addr(Addr), .WData(WData),
    .RData(rdata_v[0]), .Stall(stall_v[0]), .Done(done_v[0]), .Err(err_v[0])
  );

  dmem_responder #(.AW(10), .LAT(1)) u_lat1 (
    .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite), .Addr(Addr), .WData(WData),
    .RData(rdata_v[1]), .Stall(stall_v[1]), .Done(done_v[1]), .Err(err_v[1])
  );

  dmem_responder #(.AW(10), .LAT(15)) u_lat15 (
    .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite), .Addr(Addr), .WData(WData),
    .RData(rdata_v[2]), .Stall(stall_v[2]), .Done(done_v[2]), .Err(err_v[2])
  );

  task automatic do_reset();
    rst = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; Addr = '0; WData = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // Present a request from cycle 1 and hold it until Done; returns Stall-high
  // cycle count, the cycle Done was seen (0 = never) and RData in that cycle.
  task automatic do_req(input int sel, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] d, input bit scramble,
                        output int stall_n, output int done_at, output logic [31:0] rv);
    stall_n = 0; done_at = 0; rv = '0;
    MemRead = rd; MemWrite = wr; Addr = a; WData = d;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (stall_v[sel]) stall_n++;
      if (done_v[sel]) begin
        done_at = c;
        rv = rdata_v[sel];
        break;
      end
      @(posedge clk); #1;
      if (scramble) begin
        Addr = a ^ 32'h30;
        WData = ~d;
      end
    end
    if (done_at != 0) begin
      @(posedge clk); #1;
    end
    MemRead = 1'b0; MemWrite = 1'b0; Addr = '0; WData = '0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_checks++; if (stall_v[0] !== 1'b0) $display("FAIL reset_stall: got %b expected 0", stall_v[0]); else n_pass++;
    n_checks++; if (done_v[0] !== 1'b0) $display("FAIL reset_done: got %b expected 0", done_v[0]); else n_pass++;
    n_checks++; if (err_v[0] !== 1'b0) $display("FAIL reset_err: got %b expected 0", err_v[0]); else n_pass++;
    n_checks++; if (rdata_v[0] !== 32'h0) $display("FAIL reset_rdata: got %h expected 0", rdata_v[0]); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_store_load();
    int s, dn; logic [31:0] r;
    do_req(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, s, dn, r);
    n_checks++; if (s !== 3) $display("FAIL st_stall_cycles: got %0d expected 3", s); else n_pass++;
    n_checks++; if (dn !== 4) $display("FAIL st_done_cycle: got %0d expected 4", dn); else n_pass++;
    n_checks++; if (err_v[0] !== 1'b0) $display("FAIL st_err: got %b expected 0", err_v[0]); else n_pass++;
    do_req(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, s, dn, r);
    n_checks++; if (dn !== 4) $display("FAIL ld_done_cycle: got %0d expected 4", dn); else n_pass++;
    n_checks++; if (r !== 32'hDEADBEEF) $display("FAIL ld_rdata: got %h expected deadbeef", r); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int s, dn; logic [31:0] r;
    do_req(0, 1'b0, 1'b1, 32'h20, 32'h1, 1'b0, s, dn, r);
    n_checks++; if (dn !== 4) $display("FAIL b2b_st_done: got %0d expected 4", dn); else n_pass++;
    do_req(0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, s, dn, r);
    n_checks++; if (dn !== 4) $display("FAIL b2b_ld_gap: got %0d expected 4", dn); else n_pass++;
    n_checks++; if (r !== 32'h1) $display("FAIL b2b_ld_rdata: got %h expected 1", r); else n_pass++;
  endtask

  task automatic test_latched_operands();
    int s, dn; logic [31:0] r;
    do_req(0, 1'b0, 1'b1, 32'h50, 32'h77, 1'b1, s, dn, r);
    n_checks++; if (r !== 32'h1) $display("FAIL st_keeps_rdata: got %h expected 1", r); else n_pass++;
    do_req(0, 1'b1, 1'b0, 32'h50, 32'h0, 1'b0, s, dn, r);
    n_checks++; if (r !== 32'h77) $display("FAIL latched_wdata: got %h expected 77", r); else n_pass++;
  endtask

  task automatic test_both_err();
    int s, dn; logic [31:0] r;
    do_req(0, 1'b1, 1'b1, 32'h30, 32'h55, 1'b0, s, dn, r);
    n_checks++; if (err_v[0] !== 1'b1) $display("FAIL both_err: got %b expected 1", err_v[0]); else n_pass++;
    do_req(0, 1'b1, 1'b0, 32'h30, 32'h0, 1'b0, s, dn, r);
    n_checks++; if (r !== 32'h55) $display("FAIL both_is_store: got %h expected 55", r); else n_pass++;
    n_checks++; if (err_v[0] !== 1'b1) $display("FAIL err_sticky: got %b expected 1", err_v[0]); else n_pass++;
  endtask

  task automatic test_misaligned_alias();
    int s, dn; logic [31:0] r;
    do_reset();
    @(negedge clk);
    n_checks++; if (err_v[0] !== 1'b0) $display("FAIL err_cleared: got %b expected 0", err_v[0]); else n_pass++;
    @(posedge clk); #1;
    do_req(0, 1'b1, 1'b0, 32'h13, 32'h0, 1'b0, s, dn, r);
    n_checks++; if (r !== 32'hDEADBEEF) $display("FAIL misalign_rdata: got %h expected deadbeef", r); else n_pass++;
    n_checks++; if (err_v[0] !== 1'b1) $display("FAIL misalign_err: got %b expected 1", err_v[0]); else n_pass++;
    do_req(0, 1'b0, 1'b1, 32'h1008, 32'hCAFEF00D, 1'b0, s, dn, r);
    do_req(0, 1'b1, 1'b0, 32'h8, 32'h0, 1'b0, s, dn, r);
    n_checks++; if (r !== 32'hCAFEF00D) $display("FAIL alias_word2: got %h expected cafef00d", r); else n_pass++;
  endtask

  task automatic test_reset_mid_busy();
    int s, dn, seen; logic [31:0] r;
    do_req(0, 1'b0, 1'b1, 32'h40, 32'h0, 1'b0, s, dn, r);
    MemWrite = 1'b1; Addr = 32'h40; WData = 32'hAA;
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    n_checks++; if (stall_v[0] !== 1'b0) $display("FAIL rst_stall_drop: got %b expected 0", stall_v[0]); else n_pass++;
    MemWrite = 1'b0; Addr = '0; WData = '0;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done_v[0]) seen++;
      @(posedge clk); #1;
      if (c == 1) rst = 1'b1;
    end
    n_checks++; if (seen !== 0) $display("FAIL rst_no_done: got %0d pulses expected 0", seen); else n_pass++;
    n_checks++; if (rdata_v[0] !== 32'h0) $display("FAIL rst_rdata: got %h expected 0", rdata_v[0]); else n_pass++;
    do_req(0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0, s, dn, r);
    n_checks++; if (dn !== 4) $display("FAIL rst_ld_done: got %0d expected 4", dn); else n_pass++;
    n_checks++; if (r !== 32'h0) $display("FAIL rst_word_kept: got %h expected 0", r); else n_pass++;
  endtask

  task automatic test_lat_sweep();
    int s, dn, bad; logic [31:0] r;
    do_reset();
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (stall_v !== 3'b000 || done_v !== 3'b000) bad++;
    end
    n_checks++; if (bad !== 0) $display("FAIL idle_quiet: got %0d bad cycles expected 0", bad); else n_pass++;
    @(posedge clk); #1;
    do_req(1, 1'b0, 1'b1, 32'h4, 32'h0F0F, 1'b0, s, dn, r);
    n_checks++; if (s !== 2) $display("FAIL lat1_stall: got %0d expected 2", s); else n_pass++;
    n_checks++; if (dn !== 3) $display("FAIL lat1_done: got %0d expected 3", dn); else n_pass++;
    do_reset();
    do_req(2, 1'b0, 1'b1, 32'h4, 32'h0F0F, 1'b0, s, dn, r);
    n_checks++; if (s !== 16) $display("FAIL lat15_stall: got %0d expected 16", s); else n_pass++;
    n_checks++; if (dn !== 17) $display("FAIL lat15_done: got %0d expected 17", dn); else n_pass++;
    do_req(2, 1'b1, 1'b0, 32'h4, 32'h0, 1'b0, s, dn, r);
    n_checks++; if (dn !== 17) $display("FAIL lat15_ld_done: got %0d expected 17", dn); else n_pass++;
    n_checks++; if (r !== 32'h0F0F) $display("FAIL lat15_rdata: got %h expected 0f0f", r); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_back_to_back();
    test_latched_operands();
    test_both_err();
    test_misaligned_alias();
    test_reset_mid_busy();
    test_lat_sweep();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
